// File: rtl/multi_tokens.sv
// Token multiplier: each input token schedules `mult` output tokens.
// Define MULTI_TOKENS_BYPASS_EN for a zero-latency first output token.
module multi_tokens #(
    parameter int CNT_W  = 8,
    parameter int MULT_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a,
    input  logic [MULT_W-1:0] mult,
    output logic              b,
    input  logic              b_ready,
    output logic [CNT_W-1:0]  pending,
    output logic              overflow
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] kept;
    logic [CNT_W:0]   add;
    logic [CNT_W:0]   sum;
    logic             take;

`ifdef MULTI_TOKENS_BYPASS_EN
    assign b = (cnt != '0) | (a & (mult != '0) & ~rst);
`else
    assign b = (cnt != '0);
`endif

    assign take    = b & b_ready;
    assign pending = cnt;

    always_comb begin
        add  = '0;
        if (a)
            add = (CNT_W+1)'(mult);
        sum  = {1'b0, cnt} + add - (CNT_W+1)'(take);
        // A bypassed take from an empty counter belongs to the dropped group
        kept = cnt - CNT_W'(take & (cnt != '0));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            overflow <= 1'b0;
        end else if (sum[CNT_W]) begin
            cnt      <= kept;
            overflow <= 1'b1;
        end else begin
            cnt      <= sum[CNT_W-1:0];
        end
    end

endmodule

// File: tb/tb_multi_tokens.sv
// Directed self-checking bench for multi_tokens (default CNT_W=8, MULT_W=3).
module tb_multi_tokens;

`ifdef MULTI_TOKENS_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       a = 1'b0;
    logic [2:0] mult = '0;
    logic       b;
    logic       b_ready = 1'b0;
    logic [7:0] pending;
    logic       overflow;

    int errs = 0;
    int checks = 0;

    multi_tokens #(.CNT_W(8), .MULT_W(3)) dut (
        .clk      (clk),
        .rst      (rst),
        .a        (a),
        .mult     (mult),
        .b        (b),
        .b_ready  (b_ready),
        .pending  (pending),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int accepted;
        int expsum;
        int bcnt;
        int p;
        int t;
        int s;
        bit ovf;
        bit seen;
        int first_p;
        int prev_p;

        // reset with active inputs
        rst = 1'b1; a = 1'b1; mult = 3'd5; b_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("rst_pending", pending, 0);
            check("rst_b", b, 0);
            check("rst_ovf", overflow, 0);
        end
        rst = 1'b0; a = 1'b0; b_ready = 1'b0;
        tick();
        check("post_rst_pending", pending, 0);

        // latency and backpressure
        a = 1'b1; mult = 3'd3; b_ready = 1'b0;
        #1;
        check("lat_b_same", b, BYP);
        tick();
        a = 1'b0;
        #1;
        check("lat_pending", pending, 3);
        check("lat_b", b, 1);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_hold", pending, 3);
        end
        b_ready = 1'b1;
        bcnt = 0;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (b) bcnt++;
            tick();
            check("drain_pending", pending, (i < 3) ? 2 - i : 0);
        end
        check("drain_bcount", bcnt, 3);

        // empty with ready, then mult=0 token
        tick();
        check("empty_ready", pending, 0);
        a = 1'b1; mult = 3'd0;
        tick();
        check("mult0_pending", pending, 0);
        check("mult0_ovf", overflow, 0);
        a = 1'b0;

        // conservation
        accepted = 0;
        expsum = 0;
        for (int i = 0; i < 100; i++) begin
            a = ($urandom_range(0, 99) < 30);
            mult = 3'($urandom_range(0, 7));
            b_ready = 1'($urandom_range(0, 1));
            if (a) expsum += int'(mult);
            #1;
            if (b && b_ready) accepted++;
            tick();
        end
        a = 1'b0; b_ready = 1'b1;
        for (int i = 0; i < 500; i++) begin
            #1;
            if (b) accepted++;
            tick();
        end
        check("cons_total", accepted, expsum);
        check("cons_pending", pending, 0);
        check("cons_ovf", overflow, 0);

        // bypass / first-token timing from empty
        a = 1'b1; mult = 3'd1; b_ready = 1'b1;
        #1;
        check("byp_b_same", b, BYP);
        tick();
        a = 1'b0;
        #1;
        check("byp_pending", pending, BYP ? 0 : 1);
        check("byp_b_next", b, BYP ? 0 : 1);
        tick();
        check("byp_settle", pending, 0);

        // preload to full
        a = 1'b1; b_ready = 1'b0; mult = 3'd7;
        for (int i = 0; i < 36; i++) tick();
        mult = 3'd3;
        tick();
        check("full_pending", pending, 255);
        check("full_ovf", overflow, 0);
        mult = 3'd1; b_ready = 1'b1;
        tick();
        check("full_m1_pending", pending, 255);
        check("full_m1_ovf", overflow, 0);
        mult = 3'd2;
        tick();
        check("full_m2_pending", pending, 254);
        check("full_m2_ovf", overflow, 1);

        // saturation from reset
        rst = 1'b1; a = 1'b0;
        tick();
        check("sat_rst_ovf", overflow, 0);
        rst = 1'b0; a = 1'b1; mult = 3'd2; b_ready = 1'b1;
        p = 0; ovf = 1'b0; seen = 1'b0; first_p = -1;
        for (int i = 0; i < 1000; i++) begin
            prev_p = p;
            t = (p != 0 || BYP) ? 1 : 0;
            s = p - t + 2;
            if (s > 255) begin
                p = p - t;
                if (!ovf) first_p = prev_p;
                ovf = 1'b1;
            end else begin
                p = s;
            end
            tick();
            if (pending !== 8'(p) || overflow !== ovf) begin
                check("sat_pending", pending, p);
                check("sat_ovf", overflow, ovf);
            end
            if (overflow && !seen) begin
                seen = 1'b1;
                check("sat_first_ovf_at", prev_p, 255);
            end
        end
        check("sat_seen", seen, 1);
        check("sat_model_first", first_p, 255);
        check("sat_final_ovf", overflow, 1);
        check("sat_final_hi", (pending >= 8'd254), 1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
